// File: rtl/utmi_link_emulator.sv
// utmi_link_emulator
//   Behavioural stand-in for a UTMI PHY, used to exercise a USB link core.
//   RX path: a test harness loads packets into an injection FIFO. Each
//   rx_send pulse then replays the oldest packet to the core using the
//   UTMI receive strobes: SYNC, DATA words, EOP, then an inter-packet gap.
//   TX path: words the core transmits are captured through a one-word
//   holding register into a capture FIFO. The final word of each burst
//   is written with its last flag set, and the FIFO is read back by the
//   harness.
//   Optional feature: define UTMI_EMU_RXERR_EN to enable rx_inject_err.
//   When enabled, the packet started with rx_inject_err=1 shows rxerror
//   on its final data word. When disabled, rxerror is tied low.
// Ports:
//   clock, rstb                         clock, async active-low reset
//   attach                              device present -> linestate J/SE0
//   rx_load_valid/ready/data/last       RX injection FIFO write side
//   rx_send, rx_inject_err              start replay / corrupt the replay
//   utmi_data_in, utmi_rxvalid, utmi_rxactive, utmi_rxerror,
//   utmi_txready, utmi_linestate        PHY-to-core UTMI signals
//   utmi_data_out, utmi_txvalid,
//   utmi_op_mode                        core-to-PHY UTMI signals
//   tx_cap_valid/ready/data/last        capture FIFO read side
//   rx_busy, tx_overflow, tx_ovf_clr    status / sticky drop flag and clear
module utmi_link_emulator #(
  parameter int DATA_W      = 8,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int IPG_CYCLES  = 8,
  parameter int TXREADY_DLY = 2
) (
  input  logic              clock,
  input  logic              rstb,
  input  logic              attach,
  input  logic              rx_load_valid,
  output logic              rx_load_ready,
  input  logic [DATA_W-1:0] rx_load_data,
  input  logic              rx_load_last,
  input  logic              rx_send,
  input  logic              rx_inject_err,
  output logic [DATA_W-1:0] utmi_data_in,
  output logic              utmi_rxvalid,
  output logic              utmi_rxactive,
  output logic              utmi_rxerror,
  output logic              utmi_txready,
  output logic [1:0]        utmi_linestate,
  input  logic [DATA_W-1:0] utmi_data_out,
  input  logic              utmi_txvalid,
  input  logic [1:0]        utmi_op_mode,
  output logic              tx_cap_valid,
  input  logic              tx_cap_ready,
  output logic [DATA_W-1:0] tx_cap_data,
  output logic              tx_cap_last,
  output logic              rx_busy,
  output logic              tx_overflow,
  input  logic              tx_ovf_clr
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_ONE   = 1;
  localparam logic [TX_AW:0] TX_ONE   = 1;
  localparam logic [7:0]     IPG_LOAD = 8'(IPG_CYCLES - 1);
  localparam logic [7:0]     DLY_LOAD = 8'((TXREADY_DLY > 0) ? TXREADY_DLY - 1 : 0);

  typedef enum logic [2:0] {RX_IDLE, RX_SYNC, RX_DATA, RX_EOP, RX_GAP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_DLY, TX_DATA, TX_GAP} tx_state_t;

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  // ---------------- RX injection FIFO ----------------
  logic [DATA_W:0] rx_mem [RX_DEPTH];   // {last, data}
  logic [RX_AW:0]  rx_wr_q, rx_rd_q, pkt_cnt_q;
  logic            rx_full, rx_empty, rx_push, rx_pop;
  logic [DATA_W:0] rx_head;

  assign rx_full       = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                         (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign rx_empty      = (rx_wr_q == rx_rd_q);
  assign rx_load_ready = !rx_full;
  assign rx_push       = rx_load_valid && !rx_full;
  assign rx_head       = rx_mem[rx_rd_q[RX_AW-1:0]];

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= {rx_load_last, rx_load_data};
  end

  // ---------------- TX capture FIFO ----------------
  logic [DATA_W:0]   tx_mem [TX_DEPTH];
  logic [TX_AW:0]    tx_wr_q, tx_rd_q;
  logic              tx_full, tx_empty, tx_pop;
  logic              hold_vld_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              tx_cap, tx_fin, cap_wr, tx_push, tx_drop;
  logic [DATA_W:0]   tx_head;

  assign tx_full      = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                        (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign tx_empty     = (tx_wr_q == tx_rd_q);
  assign tx_head      = tx_mem[tx_rd_q[TX_AW-1:0]];
  assign tx_cap_valid = !tx_empty;
  assign tx_cap_data  = tx_head[DATA_W-1:0];
  assign tx_cap_last  = tx_head[DATA_W];
  assign tx_pop       = tx_cap_valid && tx_cap_ready;

  // The held word is flushed either by the next capture (not last) or by
  // txvalid falling (last), so at most one FIFO write per clock.
  assign cap_wr  = hold_vld_q && (tx_cap || tx_fin);
  assign tx_push = cap_wr && !tx_full;
  assign tx_drop = cap_wr && tx_full;

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= {tx_fin, hold_data_q};
  end

  // ---------------- Start arbitration ----------------
  // Each FSM may only start while the other is idle; TX wins a tie.
  logic tx_start, rx_start;
  assign tx_start = (tx_state_q == TX_IDLE) && utmi_txvalid &&
                    (utmi_op_mode != 2'b01) && (rx_state_q == RX_IDLE);
  assign rx_start = (rx_state_q == RX_IDLE) && rx_send && (pkt_cnt_q != '0) &&
                    (tx_state_q == TX_IDLE) && !tx_start;

  // ---------------- RX FSM ----------------
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_pop        = 1'b0;
    utmi_rxactive = 1'b0;
    utmi_rxvalid  = 1'b0;
    utmi_data_in  = '0;
    case (rx_state_q)
      RX_IDLE: if (rx_start) rx_state_d = RX_SYNC;
      RX_SYNC: begin
        utmi_rxactive = 1'b1;
        rx_state_d    = RX_DATA;
      end
      RX_DATA: begin
        utmi_rxactive = 1'b1;
        utmi_rxvalid  = !rx_empty;
        utmi_data_in  = rx_head[DATA_W-1:0];
        rx_pop        = !rx_empty;
        if (!rx_empty && rx_head[DATA_W]) rx_state_d = RX_EOP;
      end
      RX_EOP: begin
        rx_state_d = RX_GAP;
        rx_cnt_d   = IPG_LOAD;
      end
      RX_GAP: begin
        if (rx_cnt_q == 8'd0) rx_state_d = RX_IDLE;
        else                  rx_cnt_d   = rx_cnt_q - 8'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_busy        = (rx_state_q != RX_IDLE);
  assign utmi_linestate = attach ? 2'b01 : 2'b00;

  // ---------------- TX FSM ----------------
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    utmi_txready = 1'b0;
    tx_cap       = 1'b0;
    tx_fin       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          if (TXREADY_DLY == 0) begin
            tx_state_d = TX_DATA;
          end else begin
            tx_state_d = TX_DLY;
            tx_cnt_d   = DLY_LOAD;
          end
        end
      end
      TX_DLY: begin
        if (!utmi_txvalid) begin
          tx_state_d = TX_GAP;
          tx_cnt_d   = IPG_LOAD;
        end else if (tx_cnt_q == 8'd0) begin
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d   = tx_cnt_q - 8'd1;
        end
      end
      TX_DATA: begin
        utmi_txready = 1'b1;
        if (utmi_txvalid) begin
          tx_cap = 1'b1;
        end else begin
          tx_fin     = 1'b1;
          tx_state_d = TX_GAP;
          tx_cnt_d   = IPG_LOAD;
        end
      end
      TX_GAP: begin
        if (tx_cnt_q == 8'd0) tx_state_d = TX_IDLE;
        else                  tx_cnt_d   = tx_cnt_q - 8'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------- State registers ----------------
  always_ff @(posedge clock or negedge rstb) begin
    if (!rstb) begin
      rx_state_q  <= RX_IDLE;
      tx_state_q  <= TX_IDLE;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      pkt_cnt_q   <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      tx_overflow <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      if (rx_push) rx_wr_q <= rx_wr_q + RX_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_ONE;
      case ({rx_push && rx_load_last, rx_pop && rx_head[DATA_W]})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + RX_ONE;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - RX_ONE;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
      if (tx_push) tx_wr_q <= tx_wr_q + TX_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + TX_ONE;
      if (tx_cap) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= utmi_data_out;
      end else if (tx_fin) begin
        hold_vld_q  <= 1'b0;
      end
      if (tx_drop)         tx_overflow <= 1'b1;
      else if (tx_ovf_clr) tx_overflow <= 1'b0;
    end
  end

  // ---------------- Optional RX error injection ----------------
`ifdef UTMI_EMU_RXERR_EN
  logic rx_err_q;
  always_ff @(posedge clock or negedge rstb) begin
    if (!rstb)         rx_err_q <= 1'b0;
    else if (rx_start) rx_err_q <= rx_inject_err;
  end
  assign utmi_rxerror = rx_err_q && rx_pop && rx_head[DATA_W];
`else
  logic unused_inject_err;
  assign unused_inject_err = rx_inject_err;
  assign utmi_rxerror      = 1'b0;
`endif

endmodule

// File: tb/tb_utmi_link_emulator.sv
module tb_utmi_link_emulator;

  localparam int DW = 8, RXD = 16, TXD = 4, IPG = 8, TXDLY = 2;
`ifdef UTMI_EMU_RXERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock, rstb, attach;
  logic rx_load_valid, rx_load_ready, rx_load_last, rx_send, rx_inject_err;
  logic [DW-1:0] rx_load_data, utmi_data_in, utmi_data_out, tx_cap_data;
  logic utmi_rxvalid, utmi_rxactive, utmi_rxerror, utmi_txready, utmi_txvalid;
  logic [1:0] utmi_linestate, utmi_op_mode;
  logic tx_cap_valid, tx_cap_ready, tx_cap_last, rx_busy, tx_overflow, tx_ovf_clr;

  utmi_link_emulator #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD),
                       .IPG_CYCLES(IPG), .TXREADY_DLY(TXDLY)) dut (
    .clock(clock), .rstb(rstb), .attach(attach),
    .rx_load_valid(rx_load_valid), .rx_load_ready(rx_load_ready),
    .rx_load_data(rx_load_data), .rx_load_last(rx_load_last),
    .rx_send(rx_send), .rx_inject_err(rx_inject_err),
    .utmi_data_in(utmi_data_in), .utmi_rxvalid(utmi_rxvalid),
    .utmi_rxactive(utmi_rxactive), .utmi_rxerror(utmi_rxerror),
    .utmi_txready(utmi_txready), .utmi_linestate(utmi_linestate),
    .utmi_data_out(utmi_data_out), .utmi_txvalid(utmi_txvalid),
    .utmi_op_mode(utmi_op_mode), .tx_cap_valid(tx_cap_valid),
    .tx_cap_ready(tx_cap_ready), .tx_cap_data(tx_cap_data),
    .tx_cap_last(tx_cap_last), .rx_busy(rx_busy),
    .tx_overflow(tx_overflow), .tx_ovf_clr(tx_ovf_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  // Reference model state
  logic [8:0]  rx_model[$];   // {last, data} words accepted into RX FIFO
  int          rx_pkts = 0;
  logic [8:0]  pkt_q[$];      // packet about to be replayed
  logic [11:0] exp_q[$], obs_q[$];  // {busy, rxactive, rxvalid, rxerror, data}
  logic [7:0]  tx_words[$];
  logic [8:0]  tx_model[$], cap_q[$];
  bit          ovf_model = 0;
  logic        exp_rdy[$], obs_rdy[$];
  bit          rx_seen;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic load_word(input logic [7:0] d, input logic l);
    rx_load_valid = 1'b1; rx_load_data = d; rx_load_last = l;
    if (rx_model.size() < RXD) begin
      rx_model.push_back({l, d});
      if (l) rx_pkts++;
    end
    tick();
    rx_load_valid = 1'b0; rx_load_last = 1'b0;
  endtask

  task automatic load_packet(input int n);
    for (int i = 0; i < n; i++) load_word(8'($urandom_range(0, 255)), i == n - 1);
  endtask

  // Model: take the oldest packet and build the cycle-by-cycle trace it must produce.
  task automatic build_rx_exp(input bit err);
    logic [8:0] w;
    pkt_q = {}; exp_q = {};
    if (rx_pkts > 0) begin
      do begin w = rx_model.pop_front(); pkt_q.push_back(w); end while (!w[8]);
      rx_pkts--;
    end
    if (pkt_q.size() == 0) begin
      repeat (6) exp_q.push_back(12'h000);
    end else begin
      exp_q.push_back({4'b1100, 8'h00});
      foreach (pkt_q[i])
        exp_q.push_back({3'b111, ERR_EN && err && pkt_q[i][8], pkt_q[i][7:0]});
      repeat (IPG + 1) exp_q.push_back({4'b1000, 8'h00});
      repeat (2) exp_q.push_back(12'h000);
    end
    $display("rx packet len=%0d err=%0d", pkt_q.size(), err);
  endtask

  task automatic send_and_capture(input bit err, input int ncyc);
    rx_inject_err = err; rx_send = 1'b1;
    tick();
    rx_send = 1'b0; rx_inject_err = 1'b0;
    obs_q = {};
    repeat (ncyc) begin
      @(negedge clock);
      obs_q.push_back({rx_busy, utmi_rxactive, utmi_rxvalid, utmi_rxerror, utmi_data_in});
    end
    tick();
  endtask

  // Core-side transmitter; records txready each cycle until the gap ends.
  task automatic core_send(input bit with_send);
    int idx = 0, guard = 0;
    rx_seen = 0; obs_rdy = {};
    utmi_txvalid = 1'b1; utmi_data_out = tx_words[0];
    if (with_send) rx_send = 1'b1;
    while (idx < tx_words.size() && guard < 40) begin
      @(negedge clock); guard++;
      obs_rdy.push_back(utmi_txready);
      if (utmi_rxactive) rx_seen = 1;
      tick();
      rx_send = 1'b0;
      if (obs_rdy[$] == 1'b1) begin
        idx++;
        if (idx < tx_words.size()) utmi_data_out = tx_words[idx];
      end
    end
    utmi_txvalid = 1'b0;
    repeat (IPG + 1) begin
      @(negedge clock);
      obs_rdy.push_back(utmi_txready);
      if (utmi_rxactive) rx_seen = 1;
    end
    tick();
    $display("tx burst len=%0d", tx_words.size());
  endtask

  // Model: expected txready trace and capture FIFO contents (no reads during burst).
  task automatic build_tx_exp();
    exp_rdy = {};
    repeat (TXDLY + 1) exp_rdy.push_back(1'b0);
    repeat (tx_words.size() + 1) exp_rdy.push_back(1'b1);
    repeat (IPG) exp_rdy.push_back(1'b0);
    foreach (tx_words[i]) begin
      if (tx_model.size() < TXD) tx_model.push_back({1'(i == tx_words.size() - 1), tx_words[i]});
      else ovf_model = 1;
    end
  endtask

  task automatic drain_cap();
    int guard = 0;
    cap_q = {};
    tx_cap_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (!tx_cap_valid || guard > 20) break;
      cap_q.push_back({tx_cap_last, tx_cap_data});
      guard++;
    end
    tick();
    tx_cap_ready = 1'b0;
  endtask

  task automatic random_tx_words(input int n);
    tx_words = {};
    repeat (n) tx_words.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({utmi_rxvalid, utmi_rxactive, utmi_rxerror, utmi_txready, tx_cap_valid, rx_busy, tx_overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 0000000",
               {utmi_rxvalid, utmi_rxactive, utmi_rxerror, utmi_txready, tx_cap_valid, rx_busy, tx_overflow});
    end
    checks++;
    if (utmi_data_in !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", utmi_data_in); end
    @(posedge clock); #1 rstb = 1'b1;
    tick();
  endtask

  task automatic test_linestate();
    logic [1:0] exp;
    repeat (6) begin
      attach = 1'($urandom_range(0, 1));
      #1;
      exp = attach ? 2'b01 : 2'b00;
      checks++;
      if (utmi_linestate !== exp) begin errors++; $display("FAIL linestate got %b expected %b", utmi_linestate, exp); end
      tick();
    end
    attach = 1'b1;
  endtask

  task automatic test_rx_basic();
    load_word(8'h69, 1'b0); load_word(8'h00, 1'b0); load_word(8'h10, 1'b1);
    build_rx_exp(1'b0);
    send_and_capture(1'b0, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rx_basic[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rx_random();
    bit err;
    for (int k = 0; k < 3; k++) begin
      load_packet($urandom_range(1, 6));
      load_packet($urandom_range(1, 4));
      repeat (2) begin
        err = 1'($urandom_range(0, 1));
        build_rx_exp(err);
        send_and_capture(err, exp_q.size());
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rx_random[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
      end
    end
    // Nothing queued now: rx_send must be ignored.
    build_rx_exp(1'b0);
    send_and_capture(1'b0, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rx_empty_send[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < RXD; i++) load_word(8'(i * 7 + 3), i == RXD - 1);
    @(negedge clock);
    checks++;
    if (rx_load_ready !== (rx_model.size() < RXD)) begin
      errors++; $display("FAIL rx_full_ready got %b expected %b", rx_load_ready, rx_model.size() < RXD);
    end
    tick();
    load_word(8'hEE, 1'b1);   // refused by a full FIFO
    build_rx_exp(1'b0);
    send_and_capture(1'b0, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rx_full[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rx_error();
    load_packet(3);
    build_rx_exp(1'b1);
    send_and_capture(1'b1, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rx_error[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic check_tx_burst();
    checks++;
    if (obs_rdy.size() !== exp_rdy.size()) begin
      errors++; $display("FAIL txready_len got %0d expected %0d", obs_rdy.size(), exp_rdy.size());
    end else begin
      foreach (exp_rdy[i]) begin
        checks++;
        if (obs_rdy[i] !== exp_rdy[i]) begin errors++; $display("FAIL txready[%0d] got %b expected %b", i, obs_rdy[i], exp_rdy[i]); end
      end
    end
  endtask

  task automatic test_tx_basic();
    tx_words = {8'hD2, 8'hAA, 8'h55};
    build_tx_exp();
    core_send(1'b0);
    check_tx_burst();
    drain_cap();
    checks++;
    if (cap_q.size() !== tx_model.size()) begin errors++; $display("FAIL tx_basic_count got %0d expected %0d", cap_q.size(), tx_model.size()); end
    else foreach (tx_model[i]) begin
      checks++;
      if (cap_q[i] !== tx_model[i]) begin errors++; $display("FAIL tx_basic_word[%0d] got %h expected %h", i, cap_q[i], tx_model[i]); end
    end
    tx_model = {};
  endtask

  task automatic test_tx_random();
    for (int k = 0; k < 4; k++) begin
      random_tx_words($urandom_range(1, TXD));
      build_tx_exp();
      core_send(1'b0);
      check_tx_burst();
      drain_cap();
      checks++;
      if (cap_q.size() !== tx_model.size()) begin errors++; $display("FAIL tx_random_count got %0d expected %0d", cap_q.size(), tx_model.size()); end
      else foreach (tx_model[i]) begin
        checks++;
        if (cap_q[i] !== tx_model[i]) begin errors++; $display("FAIL tx_random_word[%0d] got %h expected %h", i, cap_q[i], tx_model[i]); end
      end
      tx_model = {};
    end
  endtask

  task automatic test_tx_overflow();
    random_tx_words(6);
    build_tx_exp();
    core_send(1'b0);
    @(negedge clock);
    checks++;
    if (tx_overflow !== ovf_model) begin errors++; $display("FAIL ovf_set got %b expected %b", tx_overflow, ovf_model); end
    tick();
    drain_cap();
    checks++;
    if (cap_q.size() !== tx_model.size()) begin errors++; $display("FAIL ovf_count got %0d expected %0d", cap_q.size(), tx_model.size()); end
    else foreach (tx_model[i]) begin
      checks++;
      if (cap_q[i] !== tx_model[i]) begin errors++; $display("FAIL ovf_word[%0d] got %h expected %h", i, cap_q[i], tx_model[i]); end
    end
    tx_model = {};
    checks++;
    if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", tx_overflow); end
    tx_ovf_clr = 1'b1; tick(); tx_ovf_clr = 1'b0; ovf_model = 0;
    @(negedge clock);
    checks++;
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b expected 0", tx_overflow); end
    tick();
  endtask

  task automatic test_opmode_nondriving();
    bit bad = 0;
    utmi_op_mode = 2'b01; utmi_txvalid = 1'b1; utmi_data_out = 8'h3C;
    repeat (10) begin @(negedge clock); if (utmi_txready) bad = 1; end
    tick();
    utmi_txvalid = 1'b0;
    tick(); tick();
    utmi_op_mode = 2'b00;
    checks++;
    if (bad) begin errors++; $display("FAIL opmode_txready got 1 expected 0"); end
    checks++;
    if (tx_cap_valid !== 1'b0) begin errors++; $display("FAIL opmode_capture got %b expected 0", tx_cap_valid); end
    $display("tx burst in op_mode 01 suppressed");
  endtask

  task automatic test_collision();
    load_packet(3);
    random_tx_words(2);
    build_tx_exp();
    core_send(1'b1);
    checks++;
    if (rx_seen) begin errors++; $display("FAIL collision_rxactive got 1 expected 0"); end
    check_tx_burst();
    drain_cap();
    checks++;
    if (cap_q.size() !== tx_model.size()) begin errors++; $display("FAIL collision_count got %0d expected %0d", cap_q.size(), tx_model.size()); end
    else foreach (tx_model[i]) begin
      checks++;
      if (cap_q[i] !== tx_model[i]) begin errors++; $display("FAIL collision_word[%0d] got %h expected %h", i, cap_q[i], tx_model[i]); end
    end
    tx_model = {};
    // The queued packet is still there and replays intact.
    build_rx_exp(1'b0);
    send_and_capture(1'b0, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL collision_rx[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    load_packet(5);
    rx_send = 1'b1; tick(); rx_send = 1'b0;
    repeat (3) @(negedge clock);
    tick();
    rstb = 1'b0;
    #1;
    rx_model = {}; rx_pkts = 0; tx_model = {}; ovf_model = 0;
    checks++;
    if ({utmi_rxvalid, utmi_rxactive, utmi_rxerror, utmi_txready, tx_cap_valid, rx_busy, tx_overflow} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_strobes got %b expected 0000000",
               {utmi_rxvalid, utmi_rxactive, utmi_rxerror, utmi_txready, tx_cap_valid, rx_busy, tx_overflow});
    end
    checks++;
    if (utmi_data_in !== 8'h00 || rx_load_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_fifo got data=%h ready=%b expected data=00 ready=1", utmi_data_in, rx_load_ready);
    end
    tick();
    rstb = 1'b1;
    tick();
    build_rx_exp(1'b0);
    send_and_capture(1'b0, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_after[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rstb = 1'b0; attach = 1'b0;
    rx_load_valid = 1'b0; rx_load_data = '0; rx_load_last = 1'b0;
    rx_send = 1'b0; rx_inject_err = 1'b0;
    utmi_data_out = '0; utmi_txvalid = 1'b0; utmi_op_mode = 2'b00;
    tx_cap_ready = 1'b0; tx_ovf_clr = 1'b0;
    test_reset();
    test_linestate();
    test_rx_basic();
    test_tx_basic();
    test_rx_random();
    test_tx_random();
    test_rx_full();
    test_tx_overflow();
    test_opmode_nondriving();
    test_collision();
    test_rx_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
